// File: rtl/dcache_if.sv
// CPU load/store port and backing-memory port of the data cache.
// slave is the cache's view; master is the CPU/memory side.
interface dcache_if;
  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [2:0]  cpu_memctrl;
  logic [31:0] cpu_rd;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wd, cpu_memctrl, mem_ack, mem_rdata,
    output cpu_rd, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wd, cpu_memctrl, mem_ack, mem_rdata,
    input  cpu_rd, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Latency: load hit 0 cycles; miss refills WORDS words, store writes one word through.
// Backpressure: stall held while a refill/write waits on mem_ack (unbounded).
module dcache #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 64,
  parameter int WORDS      = 4
) (
  input logic     clk,
  input logic     rst,
  dcache_if.slave bus
);
  localparam int IB  = $clog2(LINES);
  localparam int WB  = $clog2(WORDS);
  localparam int OFF = WB + 2;
  localparam int TB  = 32 - OFF - IB;
  localparam logic [WB-1:0] LAST_CNT = WB'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state, nextState;
  logic [WB-1:0] cnt;
  logic          wdone;

  logic [LINES-1:0]      validArr;
  logic [TB-1:0]         tagArr  [LINES];
  logic [DATA_WIDTH-1:0] dataArr [LINES][WORDS];

  logic [TB-1:0] addrTag;
  logic [IB-1:0] addrIdx;
  logic [WB-1:0] addrWord;
  logic [1:0]    addrByte;

  assign addrTag  = bus.cpu_addr[31:OFF+IB];
  assign addrIdx  = bus.cpu_addr[OFF+IB-1:OFF];
  assign addrWord = bus.cpu_addr[OFF-1:2];
  assign addrByte = bus.cpu_addr[1:0];

  logic hit, isByte, isHalf, refillAck, lastAck, storeHit;

  assign hit       = validArr[addrIdx] && (tagArr[addrIdx] == addrTag);
  assign isByte    = (bus.cpu_memctrl == 3'b000) || (bus.cpu_memctrl == 3'b100);
  assign isHalf    = (bus.cpu_memctrl == 3'b001) || (bus.cpu_memctrl == 3'b101);
  assign refillAck = (state == REFILL) && bus.mem_ack;
  assign lastAck   = refillAck && (cnt == LAST_CNT);
  // A held store re-presents itself after the write; only the first visit patches the line.
  assign storeHit  = (state == IDLE) && bus.cpu_we && !wdone && hit;

  logic [DATA_WIDTH-1:0] lineWord;
  logic [7:0]            loadByte;
  logic [15:0]           loadHalf;

  always_comb begin
    lineWord = dataArr[addrIdx][addrWord];
    loadByte = lineWord[{addrByte, 3'b000} +: 8];
    loadHalf = lineWord[{addrByte[1], 4'b0000} +: 16];
    case (bus.cpu_memctrl)
      3'b000:  bus.cpu_rd = {{24{loadByte[7]}}, loadByte};
      3'b001:  bus.cpu_rd = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  bus.cpu_rd = {24'h0, loadByte};
      3'b101:  bus.cpu_rd = {16'h0, loadHalf};
      default: bus.cpu_rd = lineWord;
    endcase
  end

  logic [3:0]  storeBe;
  logic [31:0] storeData;

  always_comb begin
    storeBe   = 4'b1111;
    storeData = bus.cpu_wd;
    if (isByte) begin
      storeBe   = 4'b0001 << addrByte;
      storeData = {4{bus.cpu_wd[7:0]}};
    end else if (isHalf) begin
      storeBe   = 4'b0011 << {addrByte[1], 1'b0};
      storeData = {2{bus.cpu_wd[15:0]}};
    end
  end

  always_comb begin
    nextState     = state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = {bus.cpu_addr[31:2], 2'b00};
    bus.mem_wdata = storeData;
    case (state)
      IDLE: begin
        if (bus.cpu_we) begin
          if (!wdone) nextState = WRITE;
        end else if (bus.cpu_re && !hit) begin
          nextState = REFILL;
        end
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {addrTag, addrIdx, cnt, 2'b00};
        if (lastAck) nextState = IDLE;
      end
      WRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.mem_be  = storeBe;
        if (bus.mem_ack) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.stall = (state != IDLE) | (bus.cpu_re & ~hit & ~bus.cpu_we) | (bus.cpu_we & ~wdone);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wdone    <= 1'b0;
      validArr <= '0;
    end else begin
      state <= nextState;
      wdone <= (state == WRITE) && bus.mem_ack;
      if (state == IDLE) cnt <= '0;
      else if (refillAck) cnt <= cnt + 1'b1;
      if (lastAck) validArr[addrIdx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validArr alone qualifies them.
  always_ff @(posedge clk) begin
    if (refillAck) dataArr[addrIdx][cnt] <= bus.mem_rdata;
    if (lastAck) tagArr[addrIdx] <= addrTag;
    if (storeHit) begin
      for (int b = 0; b < 4; b++) begin
        if (storeBe[b]) dataArr[addrIdx][addrWord][8*b +: 8] <= storeData[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: stimulus queues expected memory traffic and load
// results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dcache;
  logic clk;
  logic rst;
  dcache_if bus();

  dcache dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wrTxn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ldTxn_t;

  wrTxn_t      expWrQ[$];
  ldTxn_t      expLdQ[$];
  logic [31:0] expRdQ[$];
  logic [31:0] memArr[logic [31:0]];

  int nChecks = 0;
  int nErrors = 0;
  int ackDelay = 0;
  int waitCnt = 0;

  logic        prevReq = 1'b0;
  logic        prevAck = 1'b0;
  logic [31:0] prevAddr, prevWdata;
  logic [3:0]  prevBe;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] addr);
    nChecks++;
    nErrors++;
    $display("FAIL %s: unexpected at addr 0x%08h", name, addr);
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : 32'hBAD0_0000 | a;
  endfunction

  // Backing memory: acks after ackDelay idle request cycles, data driven with the ack.
  always begin
    @(posedge clk);
    #2;
    if (bus.mem_req) begin
      if (waitCnt >= ackDelay) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          logic [31:0] w;
          w = memRead(bus.mem_addr);
          for (int b = 0; b < 4; b++) if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
          memArr[bus.mem_addr] = w;
        end else begin
          bus.mem_rdata = memRead(bus.mem_addr);
        end
        waitCnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        waitCnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      waitCnt = 0;
    end
  end

  always @(negedge clk) begin : monitor
    wrTxn_t w;
    ldTxn_t l;
    logic [31:0] a;
    if (!rst) begin
      prevReq = 1'b0;
      prevAck = 1'b0;
    end else begin
      if (prevReq && !prevAck && bus.mem_req) begin
        check("mem_addr held", bus.mem_addr, prevAddr);
        check("mem_wdata held", bus.mem_wdata, prevWdata);
        check("mem_be held", {28'h0, bus.mem_be}, {28'h0, prevBe});
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (bus.mem_we) begin
          if (expWrQ.size() == 0) unexpected("mem write", bus.mem_addr);
          else begin
            w = expWrQ.pop_front();
            check("write addr", bus.mem_addr, w.addr);
            check("write be", {28'h0, bus.mem_be}, {28'h0, w.be});
            check("write data", bus.mem_wdata, w.data);
          end
        end else begin
          if (expRdQ.size() == 0) unexpected("mem read", bus.mem_addr);
          else begin
            a = expRdQ.pop_front();
            check("refill addr", bus.mem_addr, a);
          end
        end
      end
      if (bus.cpu_re && !bus.cpu_we && !bus.stall) begin
        if (expLdQ.size() == 0) unexpected("load result", bus.cpu_addr);
        else begin
          l = expLdQ.pop_front();
          check($sformatf("load 0x%08h", l.addr), bus.cpu_rd, l.data);
        end
      end
      prevReq   = bus.mem_req;
      prevAck   = bus.mem_ack;
      prevAddr  = bus.mem_addr;
      prevWdata = bus.mem_wdata;
      prevBe    = bus.mem_be;
    end
  end

  task automatic pushRefill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) expRdQ.push_back(base + 32'(4 * i));
  endtask

  task automatic pushWrite(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    wrTxn_t w;
    w.addr = addr;
    w.be   = be;
    w.data = data;
    expWrQ.push_back(w);
  endtask

  // Holds one request until stall drops, counting stalled cycles.
  task automatic cpuOp(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] ctrl, input logic [31:0] expData,
                       input int expStall, input string name);
    ldTxn_t l;
    int nStall;
    bit done;
    if (!we) begin
      l.addr = addr;
      l.data = expData;
      expLdQ.push_back(l);
    end
    @(posedge clk);
    #1;
    bus.cpu_re      = !we;
    bus.cpu_we      = we;
    bus.cpu_addr    = addr;
    bus.cpu_wd      = wd;
    bus.cpu_memctrl = ctrl;
    nStall = 0;
    done   = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (bus.stall) nStall++;
      else done = 1'b1;
    end
    if (!done) unexpected({name, " timeout"}, addr);
    check({name, " stall cycles"}, 32'(nStall), 32'(expStall));
    @(posedge clk);
    #1;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst = 1'b1;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h0;
    bus.cpu_wd = 32'h0;
    bus.cpu_memctrl = 3'b010;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    memArr[32'h100] = 32'h11; memArr[32'h104] = 32'h22;
    memArr[32'h108] = 32'h33; memArr[32'h10C] = 32'h44;
    memArr[32'h500] = 32'h55; memArr[32'h504] = 32'h56;
    memArr[32'h508] = 32'h57; memArr[32'h50C] = 32'h58;
    memArr[32'h600] = 32'h60; memArr[32'h604] = 32'h64;
    memArr[32'h608] = 32'h68; memArr[32'h60C] = 32'h6C;
    memArr[32'h700] = 32'h70; memArr[32'h704] = 32'h74;
    memArr[32'h708] = 32'h78; memArr[32'h70C] = 32'h7C;
    memArr[32'h2000] = 32'h0; memArr[32'h2004] = 32'h2004;
    memArr[32'h2008] = 32'h2008; memArr[32'h200C] = 32'h200C;

    #1 rst = 1'b0;
    #2;
    check("reset mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("reset mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("reset mem_be", {28'h0, bus.mem_be}, 32'h0);
    check("reset stall", {31'h0, bus.stall}, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Cold fill, then a hit elsewhere in the same line.
    ackDelay = 0;
    pushRefill(32'h100);
    cpuOp(1'b0, 32'h100, 32'h0, 3'b010, 32'h11, 5, "cold LW 0x100");
    cpuOp(1'b0, 32'h108, 32'h0, 3'b010, 32'h33, 0, "hit LW 0x108");

    // Sub-word stores and sign/zero extension.
    pushWrite(32'h100, 4'b0010, 32'hABABABAB);
    cpuOp(1'b1, 32'h101, 32'hAB, 3'b000, 32'h0, 2, "SB 0x101");
    cpuOp(1'b0, 32'h101, 32'h0, 3'b100, 32'h000000AB, 0, "LBU 0x101");
    cpuOp(1'b0, 32'h101, 32'h0, 3'b000, 32'hFFFFFFAB, 0, "LB 0x101");
    cpuOp(1'b0, 32'h100, 32'h0, 3'b010, 32'h0000AB11, 0, "LW 0x100 after SB");
    pushWrite(32'h10C, 4'b1100, 32'h80018001);
    cpuOp(1'b1, 32'h10E, 32'h8001, 3'b001, 32'h0, 2, "SH 0x10E");
    cpuOp(1'b0, 32'h10E, 32'h0, 3'b001, 32'hFFFF8001, 0, "LH 0x10E");
    cpuOp(1'b0, 32'h10F, 32'h0, 3'b101, 32'h00008001, 0, "LHU 0x10F misaligned");
    cpuOp(1'b0, 32'h10C, 32'h0, 3'b000, 32'h00000044, 0, "LB 0x10C");
    cpuOp(1'b0, 32'h10D, 32'h0, 3'b010, 32'h80010044, 0, "LW 0x10D misaligned");
    cpuOp(1'b0, 32'h104, 32'h0, 3'b011, 32'h00000022, 0, "code 011 as word");

    // Store miss must not allocate.
    pushWrite(32'h2000, 4'b1111, 32'hDEADBEEF);
    cpuOp(1'b1, 32'h2000, 32'hDEADBEEF, 3'b010, 32'h0, 2, "SW miss 0x2000");
    pushRefill(32'h2000);
    cpuOp(1'b0, 32'h2000, 32'h0, 3'b010, 32'hDEADBEEF, 5, "LW 0x2000 refill");

    // Conflict eviction on index 16.
    cpuOp(1'b0, 32'h100, 32'h0, 3'b010, 32'h0000AB11, 0, "LW 0x100 hit");
    pushRefill(32'h500);
    cpuOp(1'b0, 32'h500, 32'h0, 3'b010, 32'h55, 5, "LW 0x500 evict");
    pushRefill(32'h100);
    cpuOp(1'b0, 32'h100, 32'h0, 3'b010, 32'h0000AB11, 5, "LW 0x100 re-miss");
    pushRefill(32'h500);
    cpuOp(1'b0, 32'h50C, 32'h0, 3'b010, 32'h58, 5, "LW 0x50C re-miss");

    // Slow memory.
    ackDelay = 3;
    pushRefill(32'h600);
    cpuOp(1'b0, 32'h608, 32'h0, 3'b010, 32'h68, 17, "slow LW 0x608");
    ackDelay = 2;
    pushWrite(32'h604, 4'b1111, 32'h12345678);
    cpuOp(1'b1, 32'h604, 32'h12345678, 3'b010, 32'h0, 4, "slow SW 0x604");
    ackDelay = 0;
    cpuOp(1'b0, 32'h604, 32'h0, 3'b010, 32'h12345678, 0, "LW 0x604 hit");

    // Reset in the middle of a refill burst.
    expRdQ.push_back(32'h700);
    expRdQ.push_back(32'h704);
    @(posedge clk);
    #1;
    bus.cpu_re = 1'b1;
    bus.cpu_addr = 32'h700;
    bus.cpu_memctrl = 3'b010;
    acks = 0;
    for (int c = 0; c < 50 && acks < 2; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_ack) acks++;
    end
    check("mid-refill acks", 32'(acks), 32'd2);
    @(posedge clk);
    #3;
    check("mid-refill mem_req", {31'h0, bus.mem_req}, 32'h1);
    rst = 1'b0;
    bus.cpu_re = 1'b0;
    #1;
    check("async reset mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("async reset mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("async reset mem_be", {28'h0, bus.mem_be}, 32'h0);
    check("async reset stall", {31'h0, bus.stall}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    pushRefill(32'h700);
    cpuOp(1'b0, 32'h700, 32'h0, 3'b010, 32'h70, 5, "LW 0x700 after reset");
    pushRefill(32'h100);
    cpuOp(1'b0, 32'h100, 32'h0, 3'b010, 32'h0000AB11, 5, "LW 0x100 after reset");

    repeat (4) @(posedge clk);
    #1;
    check("pending refill reads", 32'(expRdQ.size()), 32'd0);
    check("pending writes", 32'(expWrQ.size()), 32'd0);
    check("pending loads", 32'(expLdQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
